game_sel_mux: RTL and testbench

Parametrised, registered N-channel selector that routes one game engine's result stream (regular roulette, even/odd roulette, dealer random number, …) to the shared display/scoring path. It replaces the free-running combinational selector with a handshaked output register. Select changes are applied only at clean transaction boundaries, so a half-delivered value from the old source can never be mixed with the new source. It sits between the game-engine outputs and the display/score datapath.

---
 rtl/game_sel_mux.sv | 86 ++++++++
 tb/tb_game_sel_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/game_sel_mux.sv
// game_sel_mux: registered N-channel selector with drain-before-switch; GAME_SEL_HOLD_EN keeps out_data after the last delivery
module game_sel_mux #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      busy,
  output logic                      sel_err
);
`ifdef GAME_SEL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] pending, pending_nx, cur_sel_nx, eff;
  logic [WIDTH-1:0] out_data_nx;
  logic out_valid_nx, sel_err_nx, take, give;
  assign in_ready = (state == PASS && (!out_valid || out_ready)) ? CHANNELS'(1) << cur_sel : '0;
  assign take = |(in_ready & in_valid);
  assign give = out_valid & out_ready;
  assign busy = state == DRAIN;
  assign eff = sel_load ? sel_in : pending;
  always_comb begin
    state_nx = state;
    cur_sel_nx = cur_sel;
    pending_nx = pending;
    sel_err_nx = 1'b0;
    out_valid_nx = take | (out_valid & !out_ready);
    out_data_nx = take ? in_data[cur_sel*WIDTH +: WIDTH] : (give && !HOLD) ? '0 : out_data;
    case (state)
      IDLE: if (sel_load) begin
        if (int'(sel_in) < CHANNELS) begin
          cur_sel_nx = sel_in;
          state_nx = PASS;
        end else sel_err_nx = 1'b1;
      end
      PASS: if (sel_load && sel_in != cur_sel) begin
        pending_nx = sel_in;
        state_nx = DRAIN;
      end
      DRAIN: begin
        pending_nx = eff;
        if (!out_valid || out_ready) begin
          if (int'(eff) < CHANNELS) begin
            cur_sel_nx = eff;
            state_nx = PASS;
          end else begin
            sel_err_nx = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cur_sel <= '0;
      pending <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state <= state_nx;
      cur_sel <= cur_sel_nx;
      pending <= pending_nx;
      out_data <= out_data_nx;
      out_valid <= out_valid_nx;
      sel_err <= sel_err_nx;
    end
  end
endmodule

// File: tb/tb_game_sel_mux.sv
// tb_game_sel_mux: scoreboard bench with a behavioural model, directed scenarios then random traffic
module tb_game_sel_mux;
  localparam int W = 5;
  localparam int CH = 3;
  localparam int DW = CH * W;
  logic clk = 1'b0, resetn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CH-1:0] in_valid = '0, in_ready;
  logic [1:0] sel_in = '0, cur_sel;
  logic sel_load = 1'b0, out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid, busy, sel_err;
  game_sel_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(2)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_in(sel_in), .sel_load(sel_load), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  int mode, msel, mpend, occ, merr;
  logic [W-1:0] last_w;
  logic [W-1:0] sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] idle_data();
`ifdef GAME_SEL_HOLD_EN
    return last_w;
`else
    return '0;
`endif
  endfunction
  function automatic logic [DW-1:0] mk(input int ch, input logic [W-1:0] v);
    logic [DW-1:0] d = DW'($urandom);
    d[ch*W +: W] = v;
    return d;
  endfunction
  task automatic model_reset();
    mode = 0; msel = 0; mpend = 0; occ = 0; merr = 0; last_w = '0;
    sb.delete();
  endtask
  // mode: 0 idle, 1 passing, 2 draining before a switch
  task automatic cycle(input logic sl, input int si, input logic [CH-1:0] iv, input logic ordy,
                       input logic [DW-1:0] d);
    int er, p;
    logic acc;
    @(negedge clk);
    chk("out_valid", out_valid, occ);
    chk("cur_sel", cur_sel, msel);
    chk("busy", busy, mode == 2);
    chk("sel_err", sel_err, merr);
    chk("out_data", out_data, occ != 0 ? sb[0] : idle_data());
    sel_load = sl; sel_in = 2'(si); in_valid = iv; out_ready = ordy; in_data = d;
    #1;
    er = (mode == 1 && (occ == 0 || ordy)) ? (1 << msel) : 0;
    chk("in_ready", in_ready, er);
    acc = (er & int'(iv)) != 0;
    if (acc) begin
      sb.push_back(d[msel*W +: W]);
      last_w = d[msel*W +: W];
    end
    merr = 0;
    case (mode)
      0: if (sl) begin
        if (si < CH) begin msel = si; mode = 1; end else merr = 1;
      end
      1: if (sl && si != msel) begin mpend = si; mode = 2; end
      default: begin
        p = sl ? si : mpend;
        mpend = p;
        if (occ == 0 || ordy) begin
          if (p < CH) begin msel = p; mode = 1; end else begin merr = 1; mode = 0; end
        end
      end
    endcase
    occ = acc ? 1 : (occ != 0 && ordy) ? 0 : occ;
  endtask
  task automatic do_reset();
    @(negedge clk);
    sel_load = 1'b0; in_valid = '0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_cur_sel", cur_sel, 0);
    @(negedge clk) resetn = 1'b1;
  endtask
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          exp = sb.pop_front();
          chk("delivered", out_data, exp);
        end
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, '1, 1'(i), mk(0, 5'd1));
    cycle(1, 1, '0, 1, mk(1, 0));
    cycle(0, 0, 3'b010, 1, mk(1, 5'd17));
    cycle(0, 0, 3'b010, 1, mk(1, 5'd3));
    cycle(0, 0, 3'b000, 1, mk(1, 0));
    cycle(0, 0, 3'b010, 0, mk(1, 5'd9));
    for (int i = 0; i < 3; i++) cycle(0, 0, 3'b010, 0, mk(1, 5'd11));
    cycle(1, 2, 3'b110, 0, mk(1, 5'd12));
    for (int i = 0; i < 2; i++) cycle(0, 0, 3'b110, 0, mk(1, 5'd13));
    cycle(0, 0, 3'b110, 1, mk(1, 5'd14));
    for (int i = 0; i < 3; i++) cycle(0, 0, 3'b110, 1, mk(2, 5'(i + 20)));
    do_reset();
    cycle(1, 3, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, 3'b001, 1, mk(0, 5'd21));
    cycle(0, 0, 3'b000, 1, 0);
    cycle(0, 0, 3'b000, 1, 0);
    cycle(0, 0, 3'b001, 0, mk(0, 5'd6));
    cycle(1, 3, 3'b001, 0, mk(0, 5'd7));
    cycle(0, 0, 3'b001, 0, mk(0, 5'd8));
    cycle(0, 0, 3'b001, 1, mk(0, 5'd8));
    for (int i = 0; i < 3; i++) cycle(0, 0, '1, 1, mk(0, 5'd2));
    cycle(1, 2, '1, 0, mk(2, 5'd30));
    cycle(0, 0, '1, 0, mk(2, 5'd31));
    cycle(1, 1, '1, 0, mk(2, 5'd31));
    cycle(0, 0, '1, 0, mk(2, 5'd31));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3), 3'($urandom),
                 $urandom_range(0, 9) < 7, DW'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
